// File: rtl/reaction_timer.sv
// reaction_timer: round FSM measuring press latency in ms after GO; REACTION_BEST_TIME_EN adds best-score output oBEST
module reaction_timer #(
    parameter int CLK_PER_MS = 50_000,
    parameter int TIMEOUT_MS = 9999,
    parameter int MS_W       = 14
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iSTART,
    input  logic            iBTN,
    input  logic            iDONE,
    output logic            oEN,
    output logic            oLED,
    output logic [MS_W-1:0] oMS,
    output logic            oVALID,
    output logic            oFALSE,
`ifdef REACTION_BEST_TIME_EN
    output logic [MS_W-1:0] oBEST,
`endif
    output logic            oTIMEOUT
);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0]   P_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [MS_W-1:0] MS_TO  = MS_W'(TIMEOUT_MS);

    typedef enum logic [1:0] {IDLE, ARMED, GO, RESULT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MS_W-1:0] cnt_q, cnt_d, ms_q, ms_d, best_q, best_d;
    logic            en_q, en_d, led_q, led_d, valid_q, valid_d;
    logic            false_q, false_d, to_q, to_d;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            ms_q    <= '0;
            best_q  <= '1;
            en_q    <= 1'b0;
            led_q   <= 1'b0;
            valid_q <= 1'b0;
            false_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ms_q    <= ms_d;
            best_q  <= best_d;
            en_q    <= en_d;
            led_q   <= led_d;
            valid_q <= valid_d;
            false_q <= false_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        ms_d    = ms_q;
        best_d  = best_q;
        en_d    = 1'b0;
        led_d   = led_q;
        valid_d = 1'b0;
        false_d = false_q;
        to_d    = to_q;
        case (state_q)
            IDLE, RESULT: if (iSTART) begin
                state_d = ARMED;
                en_d    = 1'b1;
                false_d = 1'b0;
                to_d    = 1'b0;
            end
            ARMED: if (iBTN) begin
                state_d = RESULT;
                false_d = 1'b1;
                valid_d = 1'b1;
                ms_d    = '0;
            end else if (iDONE) begin
                state_d = GO;
                led_d   = 1'b1;
                presc_d = '0;
                cnt_d   = '0;
            end
            GO: begin
                presc_d = (presc_q == P_LAST) ? '0 : presc_q + 1'b1;
                cnt_d   = (presc_q == P_LAST && cnt_q < MS_TO) ? cnt_q + 1'b1 : cnt_q;
                if (iBTN) begin
                    state_d = RESULT;
                    ms_d    = cnt_q;
                    valid_d = 1'b1;
                    led_d   = 1'b0;
                    best_d  = (cnt_q < best_q) ? cnt_q : best_q;
                end else if (cnt_q == MS_TO) begin
                    state_d = RESULT;
                    ms_d    = MS_TO;
                    to_d    = 1'b1;
                    valid_d = 1'b1;
                    led_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign oEN      = en_q;
    assign oLED     = led_q;
    assign oMS      = ms_q;
    assign oVALID   = valid_q;
    assign oFALSE   = false_q;
    assign oTIMEOUT = to_q;
`ifdef REACTION_BEST_TIME_EN
    assign oBEST    = best_q;
`else
    logic unused_best;
    assign unused_best = ^best_q;
`endif
endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Round controller and reaction-time measurement stage directly downstream of the random-delay generator.
- A start press pulses the delay generator's enable. The block waits for its done pulse, then lights the GO LED and counts milliseconds until the player presses.
- Reports the reaction time, a false start (press before GO) or a timeout (no press).
- Feeds the display/score logic.

Parameters:
- CLK_PER_MS, 50_000, iCLK cycles per millisecond (50 MHz).
- TIMEOUT_MS, 9999, ms count at which the GO phase gives up.
- MS_W, 14, width of the ms counter and result (must hold TIMEOUT_MS).

Ports:
- iCLK  input  1  clock.
- iRST  input  1  synchronous, active-high reset.
- iSTART  input  1  one-cycle start pulse (debounced).
- iBTN  input  1  one-cycle reaction press pulse (debounced).
- iDONE  input  1  delay-expired pulse from the delay generator.
- oEN  output  1  one-cycle enable pulse to the delay generator.
- oLED  output  1  GO light; high only in GO.
- oMS  output  MS_W  latched result in ms.
- oVALID  output  1  one-cycle pulse when a round ends, any outcome.
- oFALSE  output  1  level; set on false start until the next round starts.
- oTIMEOUT  output  1  level; set on timeout until the next round starts.

Behaviour:
- Reset (reset is synchronous, active-high iRST; clock iCLK): state IDLE; every output 0; prescaler and ms counter 0.
- States: IDLE, ARMED, GO, RESULT. All outputs are registered.
- IDLE/RESULT, iSTART=1:
  - next cycle oEN=1 for exactly one cycle, state ARMED;
  - oFALSE, oTIMEOUT, oVALID cleared; oMS holds its previous value.
- ARMED:
  - iBTN=1 -> RESULT; oFALSE=1, oVALID=1 (one cycle), oMS=0.
  - else iDONE=1 -> GO; oLED=1; prescaler=0, ms=0.
  - iBTN and iDONE in the same cycle count as a false start.
  - iSTART is ignored.
- GO, prescaler: counts 0..CLK_PER_MS-1. On the CLK_PER_MS-1 -> 0 wrap, ms increments (saturates at TIMEOUT_MS).
- GO, priority each cycle:
  1. iBTN=1 -> RESULT; oMS=current ms (floor, completed ms); oVALID pulse; oLED=0.
  2. else ms==TIMEOUT_MS -> RESULT; oMS=TIMEOUT_MS; oTIMEOUT=1; oVALID pulse; oLED=0.
- GO: iSTART and iDONE are ignored.
- RESULT: holds oMS/oFALSE/oTIMEOUT; iBTN ignored. Only iSTART leaves RESULT (to ARMED, as above).
- Latency:
  - iSTART -> oEN: 1 cycle.
  - iDONE -> oLED: 1 cycle.
  - iBTN -> oVALID/oMS: 1 cycle.
- Reset mid-round (any state): immediate return to IDLE with all outputs 0. The delay generator shares iRST, so no stale iDONE follows.
- Stray iDONE outside ARMED is ignored.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- Enabled:
  - adds output oBEST [MS_W-1:0], reset to all-ones (no score yet);
  - on a valid press result (not false start, not timeout), oBEST <= min(oBEST, measured ms) in the same cycle oVALID fires;
  - cleared only by iRST.
- Disabled: port and register are absent; behaviour otherwise identical.

Test Plan (CLK_PER_MS=4, TIMEOUT_MS=20):
- Reset, iSTART pulse -> oEN high exactly one cycle, 1 cycle later; state ARMED; oLED=0.
- Normal round:
  - stimulus: iDONE pulse; iBTN 30 cycles later.
  - response: oLED high 1 cycle after iDONE; oMS=7; oVALID one cycle; oFALSE=oTIMEOUT=0; oLED low.
- False start: iBTN before iDONE, and separately iBTN+iDONE same cycle -> oFALSE=1, oMS=0, oVALID pulse, oLED never high.
- Timeout: iDONE, no iBTN -> after 80 cycles of GO, oTIMEOUT=1, oMS=20, oVALID pulse; later iBTN ignored.
- Restart/reset:
  - iSTART in RESULT clears flags and re-pulses oEN.
  - iRST asserted in GO -> next cycle all outputs 0, state IDLE; iSTART in GO ignored.
- REACTION_BEST_TIME_EN rounds of 7 ms, then 12 ms, then false start -> oBEST = 7 throughout, starting from all-ones (16383).
